psram_qspi_responder: RTL and testbench



---
 rtl/psram_resp_pkg.sv | 23 ++
 rtl/psram_resp_mem.sv | 26 ++
 rtl/psram_qspi_responder.sv | 161 ++++++++++++++++
 tb/tb_psram_qspi_responder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/psram_resp_pkg.sv
// psram_resp_pkg: shared constants and types for the QSPI PSRAM responder.
//   - command opcodes understood by the responder
//   - FSM state encoding
//   - width of the address carried on the wire
package psram_resp_pkg;

  localparam logic [7:0] CMD_QPI_EN   = 8'h35;
  localparam logic [7:0] CMD_QREAD    = 8'hEB;
  localparam logic [7:0] CMD_QWRITE   = 8'h38;
  localparam logic [7:0] CMD_QPI_EXIT = 8'hF5;

  localparam int PSRAM_ADDR_BITS = 24;

  typedef enum logic [2:0] {
    ST_CMD,
    ST_ADDR,
    ST_WAIT,
    ST_RDATA,
    ST_WDATA,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/psram_resp_mem.sv
// psram_resp_mem: single-port byte RAM backing the responder.
// Ports:
//   clk_i  - system clock
//   we     - write enable; wdata is stored at addr on this edge
//   addr   - byte address, shared by read and write
//   wdata  - write byte
//   rdata  - registered read of addr (1-cycle latency, read-before-write)
// Contents are deliberately not reset.
module psram_resp_mem #(
  parameter int ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);

  logic [7:0] mem [2**ADDR_W];

  always_ff @(posedge clk_i) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/psram_qspi_responder.sv
// psram_qspi_responder: device-side QSPI PSRAM model. Decodes serial 35h
// (enter QPI), then quad EBh reads and 38h writes, served from psram_resp_mem.
// sck is oversampled on clk_i; sck high/low must each last >= 2 clk_i.
// Ports:
//   clk_i, rst_i   - system clock, synchronous active-high reset
//   sck, ce_n, din - serial clock, chip enable (low), quad data in
//   dout, douten   - quad data out, output enable (4'hF while driving)
// Build option: PSRAM_RESP_QPI_EXIT_EN - F5h in QPI mode returns to SPI mode
// once ce_n goes high.
module psram_qspi_responder
  import psram_resp_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DUMMY_CYC = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sck,
  input  logic       ce_n,
  input  logic [3:0] din,
  output logic [3:0] dout,
  output logic [3:0] douten
);

  logic        sck_q, ce_q, rise, fall;
  logic [3:0]  din_q;
  state_t      state, nxt;
  logic        qpi, is_rd, nib_lo;
  logic [7:0]  cnt, cmd_byte;
  logic        cmd_done;
  logic [19:0] shreg;
  logic [3:0]  wbuf;
  logic [PSRAM_ADDR_BITS-1:0] addr_full;
  logic [ADDR_W-1:0] addr, wr_addr, mem_addr;
  logic        wr_vld;
  logic [7:0]  wr_data, rd_data;
`ifdef PSRAM_RESP_QPI_EXIT_EN
  logic        exit_pend;
`endif

  // ce_n/din are delayed one clk_i so they line up with the sampled sck edge
  assign rise = sck & ~sck_q;
  assign fall = ~sck & sck_q;

  // Command byte as it stands once the current rise has been shifted in
  assign cmd_byte  = qpi ? {shreg[3:0], din_q} : {shreg[6:0], din_q[0]};
  assign cmd_done  = rise && (qpi ? (cnt == 8'd1) : (cnt == 8'd7));
  assign addr_full = {shreg, din_q};

  // A registered write owns the single RAM port for its one cycle
  assign mem_addr = wr_vld ? wr_addr : addr;

  psram_resp_mem #(.ADDR_W(ADDR_W)) u_mem (
    .clk_i (clk_i),
    .we    (wr_vld),
    .addr  (mem_addr),
    .wdata (wr_data),
    .rdata (rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_CMD;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (ce_q) nxt = ST_CMD;
    else begin
      case (state)
        ST_CMD: if (cmd_done) begin
          nxt = ST_IGNORE;
          if (qpi && (cmd_byte == CMD_QREAD || cmd_byte == CMD_QWRITE))
            nxt = ST_ADDR;
        end
        ST_ADDR: if (rise && cnt == 8'd5) nxt = is_rd ? ST_WAIT : ST_WDATA;
        ST_WAIT: if (rise && cnt == 8'(DUMMY_CYC - 1)) nxt = ST_RDATA;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sck_q   <= 1'b0;
      ce_q    <= 1'b1;
      din_q   <= 4'h0;
      qpi     <= 1'b0;
      is_rd   <= 1'b0;
      nib_lo  <= 1'b0;
      cnt     <= 8'd0;
      shreg   <= '0;
      wbuf    <= 4'h0;
      addr    <= '0;
      wr_addr <= '0;
      wr_vld  <= 1'b0;
      wr_data <= 8'h00;
      dout    <= 4'h0;
      douten  <= 4'h0;
`ifdef PSRAM_RESP_QPI_EXIT_EN
      exit_pend <= 1'b0;
`endif
    end else begin
      sck_q  <= sck;
      ce_q   <= ce_n;
      din_q  <= din;
      wr_vld <= 1'b0;
      // phase counter restarts on every state change and while deselected
      if (ce_q || nxt != state) cnt <= 8'd0;
      else if (rise)            cnt <= cnt + 8'd1;

      if (ce_q) begin
        // abort: drop any half byte, release the bus
        nib_lo <= 1'b0;
        dout   <= 4'h0;
        douten <= 4'h0;
`ifdef PSRAM_RESP_QPI_EXIT_EN
        if (exit_pend) qpi <= 1'b0;
        exit_pend <= 1'b0;
`endif
      end else begin
        case (state)
          ST_CMD: if (rise) begin
            shreg <= qpi ? {shreg[15:0], din_q} : {shreg[18:0], din_q[0]};
            if (cmd_done) begin
              is_rd <= (cmd_byte == CMD_QREAD);
              if (!qpi && cmd_byte == CMD_QPI_EN) qpi <= 1'b1;
`ifdef PSRAM_RESP_QPI_EXIT_EN
              if (qpi && cmd_byte == CMD_QPI_EXIT) exit_pend <= 1'b1;
`endif
            end
          end
          ST_ADDR: if (rise) begin
            shreg <= {shreg[15:0], din_q};
            if (cnt == 8'd5) addr <= ADDR_W'(addr_full);
          end
          // rd_data has tracked addr throughout WAIT, so the first byte is ready
          ST_RDATA: if (fall) begin
            douten <= 4'hF;
            dout   <= nib_lo ? rd_data[3:0] : rd_data[7:4];
            if (nib_lo) addr <= addr + ADDR_W'(1);
            nib_lo <= ~nib_lo;
          end
          ST_WDATA: if (rise) begin
            if (nib_lo) begin
              wr_vld  <= 1'b1;
              wr_addr <= addr;
              wr_data <= {wbuf, din_q};
              addr    <= addr + ADDR_W'(1);
            end else begin
              wbuf <= din_q;
            end
            nib_lo <= ~nib_lo;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_qspi_responder.sv
module tb_psram_qspi_responder;
  import psram_resp_pkg::*;

  localparam int ADDR_W    = 12;
  localparam int DUMMY_CYC = 6;

  logic       clk = 1'b0;
  logic       rst_i, sck, ce_n;
  logic [3:0] din, dout, douten;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];   // expected {douten,dout} per sck cycle

  psram_qspi_responder #(.ADDR_W(ADDR_W), .DUMMY_CYC(DUMMY_CYC)) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .sck    (sck),
    .ce_n   (ce_n),
    .din    (din),
    .dout   (dout),
    .douten (douten)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One sck period: drive din while low, sample bus just before the rise
  task automatic xfer(input logic [3:0] d, input string tag);
    din = d;
    repeat (4) @(negedge clk);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: got %h expected <scoreboard empty>", tag, {douten, dout});
    end else begin
      check(tag, {douten, dout}, exp_q.pop_front());
    end
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic begin_txn();
    ce_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_txn(input string tag);
    repeat (2) @(negedge clk);
    ce_n = 1'b1;
    repeat (8) @(negedge clk);
    check({tag, "_douten"}, {4'h0, douten}, 8'h00);
    check({tag, "_state"}, 8'(dut.state), 8'(ST_CMD));
  endtask

  task automatic spi_cmd(input logic [7:0] b);
    begin_txn();
    repeat (8) exp_q.push_back(8'h00);
    for (int i = 7; i >= 0; i--) xfer({3'b000, b[i]}, "spi_cmd");
    end_txn("spi_end");
  endtask

  task automatic q_hdr(input logic [7:0] cmd, input logic [23:0] a);
    xfer(cmd[7:4], "hdr_cmd");
    xfer(cmd[3:0], "hdr_cmd");
    for (int i = 5; i >= 0; i--) xfer(a[4*i +: 4], "hdr_addr");
  endtask

  task automatic qwrite(input logic [23:0] a, input logic [15:0] data, input int nnib);
    begin_txn();
    repeat (8 + nnib) exp_q.push_back(8'h00);
    q_hdr(CMD_QWRITE, a);
    for (int i = 0; i < nnib; i++) xfer(data[15-4*i -: 4], "wdata");
    end_txn("wr_end");
  endtask

  task automatic qread(input logic [23:0] a, input int nbytes, input logic [15:0] exp16);
    begin_txn();
    repeat (8 + DUMMY_CYC) exp_q.push_back(8'h00);
    for (int i = 0; i < 2*nbytes; i++) exp_q.push_back({4'hF, exp16[15-4*i -: 4]});
    q_hdr(CMD_QREAD, a);
    repeat (DUMMY_CYC) xfer(4'h0, "dummy");
    for (int i = 0; i < 2*nbytes; i++) xfer(4'h0, "rdata");
    end_txn("rd_end");
  endtask

  task automatic qcmd(input logic [7:0] b);
    begin_txn();
    repeat (2) exp_q.push_back(8'h00);
    xfer(b[7:4], "qcmd");
    xfer(b[3:0], "qcmd");
    repeat (2) @(negedge clk);
    check("qcmd_ignore", 8'(dut.state), 8'(ST_IGNORE));
    end_txn("qcmd_end");
  endtask

  initial begin
    rst_i = 1'b1; ce_n = 1'b1; sck = 1'b0; din = 4'h0;
    repeat (4) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_bus",   {douten, dout}, 8'h00);
    check("rst_qpi",   8'(dut.qpi),    8'h00);
    check("rst_state", 8'(dut.state),  8'(ST_CMD));

    spi_cmd(CMD_QPI_EN);
    check("qpi_set", 8'(dut.qpi), 8'h01);

    qwrite(24'h000010, 16'hA53C, 4);
    qread (24'h000010, 2, 16'hA53C);

    // wrap across the top of memory, on write and on read
    qwrite(24'(2**ADDR_W - 1), 16'h1122, 4);
    qread (24'(2**ADDR_W - 1), 2, 16'h1122);
    qread (24'h000000, 1, 16'h2200);

    // abort mid-byte: 77 lands, half of 88 is dropped
    qwrite(24'h000020, 16'hEEDD, 4);
    qwrite(24'h000020, 16'h7788, 3);
    qread (24'h000020, 2, 16'h77DD);

    qcmd(8'h9F);
    qread(24'h000010, 2, 16'hA53C);

    qcmd(CMD_QPI_EXIT);
`ifdef PSRAM_RESP_QPI_EXIT_EN
    check("qpi_exit", 8'(dut.qpi), 8'h00);
    spi_cmd(CMD_QPI_EN);
    check("qpi_reenter", 8'(dut.qpi), 8'h01);
`else
    check("qpi_kept", 8'(dut.qpi), 8'h01);
    spi_cmd(CMD_QPI_EN);
    check("qpi_still", 8'(dut.qpi), 8'h01);
`endif
    qread(24'h000010, 2, 16'hA53C);

    // reset in the middle of a transaction
    begin_txn();
    repeat (4) exp_q.push_back(8'h00);
    xfer(4'hE, "mid_cmd");
    xfer(4'hB, "mid_cmd");
    xfer(4'h0, "mid_addr");
    xfer(4'h0, "mid_addr");
    rst_i = 1'b1;
    repeat (2) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("mid_rst_qpi",   8'(dut.qpi),    8'h00);
    check("mid_rst_bus",   {douten, dout}, 8'h00);
    check("mid_rst_state", 8'(dut.state),  8'(ST_CMD));
    ce_n = 1'b1;
    repeat (4) @(negedge clk);
    check("sb_drained", 8'(exp_q.size()), 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
